// File: rtl/wired_inst_queue.sv
// ---------------------------------------------------------------------------
// wired_pkg / wired_inst_queue
//
// Purpose:
//   Dual-lane instruction queue sitting between the decoder and the backend
//   rename stage. Up to two decoded instructions are accepted per cycle and
//   compacted into a circular buffer of single-instruction slots. The oldest
//   one or two entries are presented to the backend as a masked dual-lane
//   package. A backend flush discards everything.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   flush_i      in   backend flush, empties the queue at the next edge
//   f_valid_i    in   decoder package valid
//   f_ready_o    out  queue can take a full 2-lane package (>=2 free slots)
//   f_mask_i     in   per-lane valid of decoder package, lane 0 is older
//   f_pkg_i      in   decoder instructions (2 lanes)
//   pkg_valid_o  out  package valid towards backend
//   pkg_ready_i  in   backend accepts the whole masked package
//   pkg_mask_o   out  per-lane valid of the outgoing package
//   pkg_o        out  outgoing instructions (2 lanes), lane 0 is oldest
// ---------------------------------------------------------------------------
package wired_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        valid_op;
    } pipeline_ctrl_pack_t;

endpackage

module wired_inst_queue
    import wired_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      f_valid_i,
    output logic                      f_ready_o,
    input  logic [1:0]                f_mask_i,
    input  pipeline_ctrl_pack_t [1:0] f_pkg_i,
    output logic                      pkg_valid_o,
    input  logic                      pkg_ready_i,
    output logic [1:0]                pkg_mask_o,
    output pipeline_ctrl_pack_t [1:0] pkg_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // Number of set bits in a 2-bit lane mask.
    function automatic logic [1:0] popcount2(input logic [1:0] m);
        return {1'b0, m[0]} + {1'b0, m[1]};
    endfunction

    pipeline_ctrl_pack_t mem_q [DEPTH];

    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;

    logic                push_s;
    logic                pop_s;
    logic [1:0]          npush_s;
    logic [1:0]          npop_s;
    logic                we0_s;
    logic                we1_s;
    pipeline_ctrl_pack_t wr0_s;

    // Ready looks only at the registered occupancy, so there is no
    // combinational path from any input (including pkg_ready_i) to it.
    assign f_ready_o   = (count_q <= CW'(DEPTH - 2));
    assign pkg_valid_o = (count_q != {CW{1'b0}});

    // Output mask from registered occupancy: 0, 1 or 2 lanes.
    always_comb begin
        pkg_mask_o = 2'b00;
        if (count_q == {CW{1'b0}}) begin
            pkg_mask_o = 2'b00;
        end else if (count_q == CW'(1)) begin
            pkg_mask_o = 2'b01;
        end else begin
            pkg_mask_o = 2'b11;
        end
    end

    // Read lanes; the +1 index wraps naturally since DEPTH is a power of two.
    always_comb begin
        pkg_o[0] = mem_q[rptr_q];
        pkg_o[1] = mem_q[rptr_q + PW'(1)];
    end

    // Push/pop handshakes, lane compaction and next-state pointers.
    always_comb begin
        push_s  = f_valid_i && f_ready_o;
        pop_s   = pkg_valid_o && pkg_ready_i;
        npush_s = 2'd0;
        npop_s  = 2'd0;
        we0_s   = 1'b0;
        we1_s   = 1'b0;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;

        // A lone lane-1 instruction is compacted down into the first slot.
        if (f_mask_i == 2'b10) begin
            wr0_s = f_pkg_i[1];
        end else begin
            wr0_s = f_pkg_i[0];
        end

        if (push_s) begin
            npush_s = popcount2(f_mask_i);
        end else begin
            npush_s = 2'd0;
        end

        if (pop_s) begin
            npop_s = popcount2(pkg_mask_o);
        end else begin
            npop_s = 2'd0;
        end

        if (flush_i) begin
            rptr_d  = {PW{1'b0}};
            wptr_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            we0_s   = (npush_s != 2'd0);
            we1_s   = (npush_s == 2'd2);
            rptr_d  = rptr_q + PW'(npop_s);
            wptr_d  = wptr_q + PW'(npush_s);
            count_d = count_q + CW'(npush_s) - CW'(npop_s);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= {PW{1'b0}};
            wptr_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Slot storage; contents are never reset, validity comes from count_q.
    always_ff @(posedge clk) begin
        if (we0_s) begin
            mem_q[wptr_q] <= wr0_s;
        end
        if (we1_s) begin
            mem_q[wptr_q + PW'(1)] <= f_pkg_i[1];
        end
    end

endmodule

// File: tb/tb_wired_inst_queue.sv
module tb_wired_inst_queue;
    import wired_pkg::*;

    localparam int DEPTH = 8;

    logic                      clk;
    logic                      rst_n;
    logic                      flush_i;
    logic                      f_valid_i;
    logic                      f_ready_o;
    logic [1:0]                f_mask_i;
    pipeline_ctrl_pack_t [1:0] f_pkg_i;
    logic                      pkg_valid_o;
    logic                      pkg_ready_i;
    logic [1:0]                pkg_mask_o;
    pipeline_ctrl_pack_t [1:0] pkg_o;

    wired_inst_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .f_valid_i   (f_valid_i),
        .f_ready_o   (f_ready_o),
        .f_mask_i    (f_mask_i),
        .f_pkg_i     (f_pkg_i),
        .pkg_valid_o (pkg_valid_o),
        .pkg_ready_i (pkg_ready_i),
        .pkg_mask_o  (pkg_mask_o),
        .pkg_o       (pkg_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        flush;
        logic        fv;
        logic [1:0]  fm;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic        pr;
        logic        ev;
        logic [1:0]  em;
        logic        er;
        logic [31:0] ep0;
        logic [31:0] ep1;
    } vec_t;

    vec_t tbl[20];

    function automatic pipeline_ctrl_pack_t mk(input logic [31:0] pc);
        pipeline_ctrl_pack_t p;
        p.pc       = pc;
        p.inst     = ~pc;
        p.rd       = pc[6:2];
        p.valid_op = 1'b1;
        return p;
    endfunction

    function automatic vec_t mkv(input logic fl, input logic fv, input logic [1:0] fm,
                                 input logic [31:0] pc0, input logic [31:0] pc1,
                                 input logic pr, input logic ev, input logic [1:0] em,
                                 input logic er, input logic [31:0] ep0,
                                 input logic [31:0] ep1);
        vec_t v;
        v.flush = fl; v.fv = fv; v.fm = fm; v.pc0 = pc0; v.pc1 = pc1; v.pr = pr;
        v.ev = ev; v.em = em; v.er = er; v.ep0 = ep0; v.ep1 = ep1;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic fv, input logic [1:0] fm,
                         input logic [31:0] pc0, input logic [31:0] pc1, input logic pr);
        flush_i     = fl;
        f_valid_i   = fv;
        f_mask_i    = fm;
        f_pkg_i[0]  = mk(pc0);
        f_pkg_i[1]  = mk(pc1);
        pkg_ready_i = pr;
    endtask

    // Apply one table row across one edge and compare the resulting outputs.
    task automatic step(input vec_t v, input int idx);
        drive(v.flush, v.fv, v.fm, v.pc0, v.pc1, v.pr);
        @(posedge clk);
        #1;
        check($sformatf("tbl%0d_valid", idx), {63'd0, pkg_valid_o}, {63'd0, v.ev});
        check($sformatf("tbl%0d_mask", idx), {62'd0, pkg_mask_o}, {62'd0, v.em});
        check($sformatf("tbl%0d_ready", idx), {63'd0, f_ready_o}, {63'd0, v.er});
        if (v.em[0]) check($sformatf("tbl%0d_pc0", idx), {32'd0, pkg_o[0].pc}, {32'd0, v.ep0});
        if (v.em[1]) check($sformatf("tbl%0d_pc1", idx), {32'd0, pkg_o[1].pc}, {32'd0, v.ep1});
    endtask

    // Reference model: plain queue of stored instructions in age order.
    pipeline_ctrl_pack_t mq[$];

    task automatic model_check(input string tag);
        logic [1:0] em;
        em = (mq.size() == 0) ? 2'b00 : ((mq.size() == 1) ? 2'b01 : 2'b11);
        check({tag, "_valid"}, {63'd0, pkg_valid_o}, {63'd0, (mq.size() != 0)});
        check({tag, "_mask"}, {62'd0, pkg_mask_o}, {62'd0, em});
        check({tag, "_ready"}, {63'd0, f_ready_o}, {63'd0, ((DEPTH - mq.size()) >= 2)});
        if (mq.size() >= 1) check({tag, "_lane0"}, pkg_o[0], mq[0]);
        if (mq.size() >= 2) check({tag, "_lane1"}, pkg_o[1], mq[1]);
    endtask

    initial begin
        logic [31:0] exp_next;
        int          sz;
        logic        rdy;
        logic [31:0] r0;
        logic [31:0] r1;

        // Directed rows: single push, compaction, full/stall, wrap, flush.
        tbl[0]  = mkv(0, 1, 2'b01, 32'h1c000000, 32'h0, 0, 1, 2'b01, 1, 32'h1c000000, 32'h0);
        tbl[1]  = mkv(0, 0, 2'b00, 32'h0, 32'h0, 1, 0, 2'b00, 1, 32'h0, 32'h0);
        tbl[2]  = mkv(0, 1, 2'b10, 32'hdead, 32'h100, 0, 1, 2'b01, 1, 32'h100, 32'h0);
        tbl[3]  = mkv(0, 1, 2'b11, 32'h104, 32'h108, 0, 1, 2'b11, 1, 32'h100, 32'h104);
        tbl[4]  = mkv(0, 0, 2'b00, 32'h0, 32'h0, 1, 1, 2'b01, 1, 32'h108, 32'h0);
        tbl[5]  = mkv(0, 0, 2'b00, 32'h0, 32'h0, 1, 0, 2'b00, 1, 32'h0, 32'h0);
        tbl[6]  = mkv(0, 1, 2'b11, 32'h200, 32'h204, 0, 1, 2'b11, 1, 32'h200, 32'h204);
        tbl[7]  = mkv(0, 1, 2'b11, 32'h208, 32'h20c, 0, 1, 2'b11, 1, 32'h200, 32'h204);
        tbl[8]  = mkv(0, 1, 2'b11, 32'h210, 32'h214, 0, 1, 2'b11, 1, 32'h200, 32'h204);
        tbl[9]  = mkv(0, 1, 2'b11, 32'h218, 32'h21c, 0, 1, 2'b11, 0, 32'h200, 32'h204);
        tbl[10] = mkv(0, 1, 2'b11, 32'h300, 32'h304, 0, 1, 2'b11, 0, 32'h200, 32'h204);
        tbl[11] = mkv(0, 1, 2'b11, 32'h308, 32'h30c, 1, 1, 2'b11, 1, 32'h208, 32'h20c);
        tbl[12] = mkv(0, 0, 2'b00, 32'h0, 32'h0, 1, 1, 2'b11, 1, 32'h210, 32'h214);
        tbl[13] = mkv(0, 0, 2'b00, 32'h0, 32'h0, 1, 1, 2'b11, 1, 32'h218, 32'h21c);
        tbl[14] = mkv(0, 1, 2'b11, 32'h220, 32'h224, 1, 1, 2'b11, 1, 32'h220, 32'h224);
        tbl[15] = mkv(0, 1, 2'b11, 32'h230, 32'h234, 0, 1, 2'b11, 1, 32'h220, 32'h224);
        tbl[16] = mkv(0, 1, 2'b01, 32'h238, 32'h0, 0, 1, 2'b11, 1, 32'h220, 32'h224);
        tbl[17] = mkv(1, 1, 2'b11, 32'h900, 32'h904, 1, 0, 2'b00, 1, 32'h0, 32'h0);
        tbl[18] = mkv(0, 0, 2'b00, 32'h0, 32'h0, 0, 0, 2'b00, 1, 32'h0, 32'h0);
        tbl[19] = mkv(0, 1, 2'b11, 32'h40, 32'h44, 0, 1, 2'b11, 1, 32'h40, 32'h44);

        rst_n = 1'b0;
        drive(0, 0, 2'b00, 32'h0, 32'h0, 0);
        #12;
        check("rst_valid", {63'd0, pkg_valid_o}, 64'd0);
        check("rst_mask", {62'd0, pkg_mask_o}, 64'd0);
        check("rst_ready", {63'd0, f_ready_o}, 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) step(tbl[i], i);

        // Stream: push two, pop two every cycle; order must be preserved across wrap.
        drive(1, 0, 2'b00, 32'h0, 32'h0, 0);
        @(posedge clk);
        #1;
        exp_next = 32'h1000;
        for (int c = 0; c < 20; c++) begin
            drive(0, 1, 2'b11, 32'h1000 + 32'(c * 8), 32'h1004 + 32'(c * 8), 1);
            @(posedge clk);
            #1;
            check("stream_mask", {62'd0, pkg_mask_o}, 64'd3);
            check("stream_ready", {63'd0, f_ready_o}, 64'd1);
            check("stream_pc0", {32'd0, pkg_o[0].pc}, {32'd0, exp_next});
            check("stream_pc1", {32'd0, pkg_o[1].pc}, {32'd0, exp_next + 32'd4});
            exp_next = exp_next + 32'd8;
        end

        // Bring occupancy to 3, then drop reset between edges.
        drive(0, 1, 2'b01, 32'h5000, 32'h0, 0);
        @(posedge clk);
        #1;
        drive(0, 0, 2'b00, 32'h0, 32'h0, 0);
        check("pre_arst_mask", {62'd0, pkg_mask_o}, 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {63'd0, pkg_valid_o}, 64'd0);
        check("arst_mask", {62'd0, pkg_mask_o}, 64'd0);
        check("arst_ready", {63'd0, f_ready_o}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mq.delete();

        // Random traffic against the queue model.
        for (int c = 0; c < 400; c++) begin
            model_check($sformatf("rnd%0d", c));
            r0 = $urandom;
            r1 = $urandom;
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), r0, r1, ($urandom_range(0, 2) != 0));
            sz  = mq.size();
            rdy = ((DEPTH - sz) >= 2);
            @(posedge clk);
            #1;
            if (flush_i) begin
                mq.delete();
            end else begin
                if (pkg_ready_i && sz != 0) begin
                    for (int k = 0; k < 2 && k < sz; k++) void'(mq.pop_front());
                end
                if (f_valid_i && rdy) begin
                    if (f_mask_i[0]) mq.push_back(mk(r0));
                    if (f_mask_i[1]) mq.push_back(mk(r1));
                end
            end
        end
        model_check("rnd_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wired_inst_queue.md
# wired_inst_queue

Dual-lane instruction queue between the decoder and `wired_backend`. It accepts up to two decoded `pipeline_ctrl_pack_t` entries per cycle from the front end. It stores them in a circular buffer of single-instruction slots and presents the oldest one or two as a masked dual-lane package to the backend's rename stage. It decouples front-end bubbles from backend stalls and discards all contents on a backend flush.

## Interface

Parameters:
- `DEPTH`, 8: number of single-instruction slots. Power of two, ≥4.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `flush_i`  in  1  backend flush (`c_flush`); empties the queue.
- `f_valid_i`  in  1  decoder package valid.
- `f_ready_o`  out  1  queue can accept a full 2-lane package.
- `f_mask_i`  in  2  per-lane valid of the decoder package; lane 0 is older.
- `f_pkg_i`  in  2×`pipeline_ctrl_pack_t`  decoder instructions.
- `pkg_valid_o`  out  1  to backend `pkg_valid_i`.
- `pkg_ready_i`  in  1  from backend `pkg_ready_o`.
- `pkg_mask_o`  out  2  to backend `pkg_mask_i`.
- `pkg_o`  out  2×`pipeline_ctrl_pack_t`  to backend `pkg_i`.

## Operation

State:
- Storage array `DEPTH` × `pipeline_ctrl_pack_t`. Not reset.
- `rptr` and `wptr`, each `$clog2(DEPTH)` bits. Both wrap modulo `DEPTH`.
- `count`, `$clog2(DEPTH)+1` bits, range 0..`DEPTH`.

Push:
- Push fires when `f_valid_i && f_ready_o`.
- `npush` = popcount(`f_mask_i`).
- Masked lanes are compacted, keeping order:
  - 2'b11: lane0 → slot `wptr`, lane1 → slot `wptr+1`.
  - 2'b01: lane0 → slot `wptr`.
  - 2'b10: lane1 → slot `wptr`.
  - 2'b00: no write, no pointer change.
- `wptr` advances by `npush`.

Ready:
- `f_ready_o` = (`DEPTH` − `count`) ≥ 2.
- It uses the registered `count` only. It ignores any same-cycle pop and any input signal, so there is no combinational input-to-ready path.

Output:
- `pkg_valid_o` = `count` ≠ 0.
- `pkg_o[0]` = slot `rptr`; `pkg_o[1]` = slot `rptr+1` (wrapped).
- `pkg_mask_o` is:
  - 2'b00 if `count`=0,
  - 2'b01 if `count`=1,
  - 2'b11 if `count`≥2.
- `pkg_o` is don't-care in any lane whose mask bit is 0.

Pop:
- Pop fires when `pkg_valid_o && pkg_ready_i`.
- All masked lanes are consumed together, matching the backend's all-or-nothing `r_issue`.
- `npop` = popcount(`pkg_mask_o`); `rptr` advances by `npop`.

Count update:
- `count_next` = `count` + `npush` − `npop` for simultaneous push and pop.
- Never exceeds `DEPTH`, because push requires ≥2 free slots.

Flush:
- When `flush_i` is high at a rising edge, `rptr`, `wptr` and `count` go to 0.
- This overrides any push or pop in the same cycle.
- Outputs are not gated by `flush_i` in the flush cycle. The backend handles its own flush-cycle capture.

## Timing

- Reset (async assert): `rptr`=`wptr`=`count`=0.
  - Resulting outputs: `pkg_valid_o`=0, `pkg_mask_o`=2'b00, `f_ready_o`=1.
- Push-to-output latency: 1 cycle. An instruction written at edge N appears on `pkg_o` in cycle N+1. There is no bypass from `f_pkg_i` to `pkg_o`.
- All outputs derive from registers only; none combinationally depends on any input.
- Full boundary: `count` = `DEPTH`−1 or `DEPTH` → `f_ready_o`=0, even if a pop happens that cycle.
- Empty boundary: `count`=0 → `pkg_valid_o`=0, and a concurrent push is not visible until the next cycle.
- Wrap-around: a two-lane push at `wptr`=`DEPTH`−1 writes slots `DEPTH`−1 and 0. A two-lane read at `rptr`=`DEPTH`−1 reads the same two slots in order.
- Held output: while `pkg_ready_i`=0, `pkg_o` and `pkg_mask_o` stay stable except for a mask upgrade from 2'b01 to 2'b11 when a new entry arrives.
- Flush: the cycle after `flush_i`, `pkg_valid_o`=0 and `f_ready_o`=1.
- Reset mid-operation: same state as the initial reset, with storage contents ignored.

## Test plan

- **Reset then single push.** Reset, then push mask 2'b01 with pc=0x1c000000. Required: next cycle `pkg_valid_o`=1, `pkg_mask_o`=2'b01, `pkg_o[0].pc`=0x1c000000; after pop with `pkg_ready_i`=1, `pkg_valid_o`=0.
- **Compaction and order.** Push 2'b10 (pc A), then 2'b11 (pcs B, C), with `pkg_ready_i`=0. Required: output mask 2'b11 with lane0=A, lane1=B. After one pop, mask 2'b01 with lane0=C.
- **Full and stall, DEPTH=8.** Push four 2'b11 packages with `pkg_ready_i`=0. Required: `f_ready_o` falls after `count` reaches 7/8. Then with `pkg_ready_i`=1 one cycle, `count` drops 8→6 and `f_ready_o` returns to 1 the next cycle.
- **Simultaneous push/pop with wrap.** Stream 2'b11 pushes while the backend pops every cycle for 20 cycles. Required: pcs exit in strictly increasing order across pointer wrap, with no loss or duplication, and `count` stays at 2.
- **Flush.** Hold 5 entries, then assert `flush_i` together with a push 2'b11 and a pop. Required: next cycle `count`=0, `pkg_valid_o`=0, `f_ready_o`=1. The pushed pcs never appear on `pkg_o`.
- **Async reset mid-stream.** Drop `rst_n` between clock edges while `count`=3. Required: `pkg_valid_o`=0 and `f_ready_o`=1 immediately, without waiting for `clk`.
